// File: rtl/sync_and_debounce_multi.sv
// sync_and_debounce_multi: per-channel synchroniser and tick-qualified debouncer with rise/fall pulses; define SYNC_DEBOUNCE_HOLD_EN for long-press hold pulses
module sync_and_debounce_multi #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int SYNC_STAGES = 3,
  parameter int HOLD_DEPTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change,
  output logic [WIDTH-1:0] hold
);
  logic [SYNC_STAGES-1:0] sync_q [WIDTH];
  logic [DEPTH-1:0]       cnt    [WIDTH];
  logic [WIDTH-1:0]       s, full, m, acc;
  always_comb begin
    s = '0;
    full = '0;
    for (int i = 0; i < WIDTH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
      full[i] = &cnt[i];
    end
    m = sw_out ^ s;
    acc = m & full & {WIDTH{tick}};
  end
  // a saturated counter on a tick accepts the new level instead of wrapping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_q[i] <= '0;
        cnt[i] <= '0;
      end
      sw_out <= '0;
      rise <= '0;
      fall <= '0;
      any_change <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw_in[i]};
        cnt[i] <= (!m[i] || acc[i]) ? '0 : cnt[i] + DEPTH'(tick);
      end
      sw_out <= sw_out ^ acc;
      rise <= acc & s;
      fall <= acc & ~s;
      any_change <= |acc;
    end
`ifdef SYNC_DEBOUNCE_HOLD_EN
  logic [HOLD_DEPTH-1:0] hcnt [WIDTH];
  // pulse on the tick that saturates the counter, so one pulse per press
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) hcnt[i] <= '0;
      hold <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hcnt[i] <= !sw_out[i] ? '0 : hcnt[i] + HOLD_DEPTH'(tick && !(&hcnt[i]));
        hold[i] <= sw_out[i] && tick && (~hcnt[i] == HOLD_DEPTH'(1));
      end
    end
`else
  assign hold = WIDTH'(HOLD_DEPTH'(0));
`endif
endmodule

// File: tb/tb_sync_and_debounce_multi.sv
// tb_sync_and_debounce_multi: table vectors plus hand sequences, scoreboard of expected pulse edges
module tb_sync_and_debounce_multi;
  localparam int LAT = 18;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b1;
  logic [3:0] sw_in = '0;
  logic [3:0] sw_out, rise, fall, hold;
  logic any_change;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit run = 0;
  bit tick_mode = 0;
  int frz_lo = 0;
  int frz_hi = 0;
  typedef struct {int cyc; int ch; int kind;} ev_t;
  ev_t q[$];
  typedef struct {logic [3:0] sw; int dur; logic [3:0] exp;} vec_t;
  vec_t tbl[6];
  logic [3:0] er, ef, eh, cur;
  int e, ea;

  sync_and_debounce_multi #(.WIDTH(4), .DEPTH(4), .SYNC_STAGES(3), .HOLD_DEPTH(5)) dut (
    .clk(clk), .reset(reset), .tick(tick), .sw_in(sw_in), .sw_out(sw_out),
    .rise(rise), .fall(fall), .any_change(any_change), .hold(hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t v;
    v.cyc = c;
    v.ch = ch;
    v.kind = kind;
    q.push_back(v);
  endtask

  function automatic bit tick_at(input int t);
    return (t % 4 == 0) && !(t >= frz_lo && t < frz_hi);
  endfunction

  // edge of the 16th tick-qualified edge once the synchroniser has delivered the change
  function automatic int exp_edge(input int e0);
    int n = 0;
    for (int t = e0 + 3; t < e0 + 1000; t++)
      if (tick_at(t)) begin
        n++;
        if (n == 16) return t;
      end
    return -1;
  endfunction

  always @(negedge clk) tick = tick_mode ? tick_at(cyc + 1) : 1'b1;

  always @(negedge clk)
    if (run && !reset) begin
      er = '0;
      ef = '0;
      eh = '0;
      for (int k = q.size() - 1; k >= 0; k--)
        if (q[k].cyc <= cyc) begin
          if (q[k].cyc < cyc) chk("stale_event", 32'(q[k].cyc), 32'(cyc));
          else if (q[k].kind == 0) er[q[k].ch] = 1'b1;
          else if (q[k].kind == 1) ef[q[k].ch] = 1'b1;
          else eh[q[k].ch] = 1'b1;
          q.delete(k);
        end
      chk("rise", 32'(rise), 32'(er));
      chk("fall", 32'(fall), 32'(ef));
      chk("any_change", 32'(any_change), 32'(|(er | ef)));
      chk("hold", 32'(hold), 32'(eh));
    end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0001, 25, 4'b0001};
    tbl[1] = '{4'b0000, 25, 4'b0000};
    tbl[2] = '{4'b1010, 25, 4'b1010};
    tbl[3] = '{4'b0110, 25, 4'b0110};
    tbl[4] = '{4'b1111, 25, 4'b1111};
    tbl[5] = '{4'b0000, 25, 4'b0000};
    repeat (3) @(negedge clk);
    chk("reset_sw_out", 32'(sw_out), 0);
    chk("reset_pulses", 32'({rise, fall, hold, any_change}), 0);
    reset = 1'b0;
    run = 1;
    cur = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = cyc + 1;
      for (int ch = 0; ch < 4; ch++)
        if (tbl[i].sw[ch] != cur[ch]) push(e + LAT, ch, tbl[i].sw[ch] ? 0 : 1);
      sw_in = tbl[i].sw;
      cur = tbl[i].sw;
      repeat (tbl[i].dur - 1) @(negedge clk);
      chk($sformatf("vec%0d_sw_out", i), 32'(sw_out), 32'(tbl[i].exp));
    end
    // bounce on channel 1: only the final stable level is accepted
    @(negedge clk);
    sw_in[1] = 1'b1;
    repeat (10) @(negedge clk);
    sw_in[1] = 1'b0;
    repeat (2) @(negedge clk);
    sw_in[1] = 1'b1;
    e = cyc + 1;
    push(e + LAT, 1, 0);
    repeat (LAT - 2) @(negedge clk);
    chk("bounce_early", 32'(sw_out), 0);
    repeat (4) @(negedge clk);
    chk("bounce_done", 32'(sw_out), 32'(4'b0010));
    sw_in[1] = 1'b0;
    e = cyc + 1;
    push(e + LAT, 1, 1);
    repeat (22) @(negedge clk);
    // tick every 4th edge with a 20-cycle freeze mid-window
    tick_mode = 1;
    repeat (4) @(negedge clk);
    sw_in[2] = 1'b1;
    e = cyc + 1;
    frz_lo = e + 20;
    frz_hi = e + 40;
    ea = exp_edge(e);
    push(ea, 2, 0);
    repeat (ea - cyc - 2) @(negedge clk);
    chk("tick_early", 32'(sw_out), 0);
    repeat (5) @(negedge clk);
    chk("tick_done", 32'(sw_out), 32'(4'b0100));
    sw_in[2] = 1'b0;
    e = cyc + 1;
    frz_lo = 0;
    frz_hi = 0;
    ea = exp_edge(e);
    push(ea, 2, 1);
    repeat (ea - cyc + 3) @(negedge clk);
    chk("tick_release", 32'(sw_out), 0);
    tick_mode = 0;
    repeat (4) @(negedge clk);
    // reset mid-window on channel 3 while channel 0 is debounced high
    sw_in[0] = 1'b1;
    e = cyc + 1;
    push(e + LAT, 0, 0);
    repeat (20) @(negedge clk);
    sw_in[3] = 1'b1;
    repeat (13) @(negedge clk);
    chk("pre_reset", 32'(sw_out), 32'(4'b0001));
    #2 reset = 1'b1;
    #1;
    chk("async_reset_sw_out", 32'(sw_out), 0);
    chk("async_reset_pulses", 32'({rise, fall, hold, any_change}), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    e = cyc + 1;
    push(e + LAT, 0, 0);
    push(e + LAT, 3, 0);
    repeat (LAT - 2) @(negedge clk);
    chk("post_reset_early", 32'(sw_out), 0);
    repeat (4) @(negedge clk);
    chk("post_reset_done", 32'(sw_out), 32'(4'b1001));
    sw_in = '0;
    e = cyc + 1;
    push(e + LAT, 0, 1);
    push(e + LAT, 3, 1);
    repeat (22) @(negedge clk);
    // long press on channel 0
    sw_in[0] = 1'b1;
    e = cyc + 1;
    push(e + LAT, 0, 0);
`ifdef SYNC_DEBOUNCE_HOLD_EN
    push(e + LAT + 31, 0, 2);
`endif
    repeat (90) @(negedge clk);
    chk("long_press", 32'(sw_out), 32'(4'b0001));
    sw_in[0] = 1'b0;
    e = cyc + 1;
    push(e + LAT, 0, 1);
    repeat (25) @(negedge clk);
    chk("final_sw_out", 32'(sw_out), 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_and_debounce_multi.md
Name: sync_and_debounce_multi

Overview:
Multi-channel successor to the single-switch synchroniser/debouncer. Each of WIDTH asynchronous inputs (buttons, DIP switches) passes through a SYNC_STAGES flop synchroniser and a per-channel stability counter. Each channel produces a debounced level plus registered single-cycle rise and fall pulses. A shared `tick` strobe lets one prescaler stretch the debounce window for all channels. Sits between board pins and arbiter request/control logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- DEPTH, 8, debounce counter width; the window is 2^DEPTH tick-qualified cycles.
- SYNC_STAGES, 3, synchroniser flops per channel (>=2).
- HOLD_DEPTH, 12, hold counter width; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  count-enable strobe; tie to 1 for per-clock debouncing.
- sw_in  in  WIDTH  raw asynchronous inputs.
- sw_out  out  WIDTH  debounced levels.
- rise  out  WIDTH  1-cycle pulse when sw_out[i] goes 0->1.
- fall  out  WIDTH  1-cycle pulse when sw_out[i] goes 1->0.
- any_change  out  1  registered OR of rise and fall across all channels, same cycle as the pulses.
- hold  out  WIDTH  long-press pulse (optional feature); 0 otherwise.

Behaviour:
- Reset (async, active-high) clears to 0: all sync flops, counters, sw_out, rise, fall, any_change, hold. Reset asserted mid-debounce discards progress; no pulses are emitted on reset entry or exit.
- Sync: s[i] is the last stage of a SYNC_STAGES shift register clocked every clk; it ignores tick.
- Mismatch m[i] = sw_out[i] XOR s[i].
- Counter cnt[i], DEPTH bits, updated every clk:
  - m=0: cnt <= 0, regardless of tick.
  - m=1, tick=1, cnt != all-ones: cnt <= cnt+1.
  - m=1, tick=1, cnt == all-ones: sw_out[i] <= s[i]; cnt <= 0; the matching rise/fall pulse is asserted.
  - m=1, tick=0: cnt holds.
- Any glitch that clears m before acceptance restarts the window from 0.
- Latency with tick=1: a stable input change first sampled at edge E appears on sw_out at edge E+SYNC_STAGES+2^DEPTH-1. With defaults this is 258 edges. With tick every Nth cycle, the window is 2^DEPTH ticks.
- rise/fall/any_change are registered and high exactly one cycle, coincident with the sw_out update. rise and fall are never both high for the same channel.
- Channels are fully independent. Simultaneous acceptances on several channels in one cycle are all reported in that cycle.
- No wrap-around: cnt never increments past all-ones.

Optional Feature:
- Macro SYNC_DEBOUNCE_HOLD_EN.
- Defined: per-channel hold counter, HOLD_DEPTH bits.
  - Cleared while sw_out[i]=0.
  - Increments on tick while sw_out[i]=1.
  - Saturates at all-ones.
  - hold[i] pulses for 1 cycle on the tick where the counter reaches all-ones.
  - One pulse per press; no auto-repeat until release and re-press.
- Undefined: no hold logic is synthesised; hold is driven constant 0. The port list is unchanged.

Test Plan:
All scenarios use WIDTH=4, DEPTH=4, SYNC_STAGES=3, tick=1 unless stated.
1. Raise sw_in[0] and hold it; first sampling edge E -> sw_out[0]=1 and rise[0]=1 for one cycle at edge E+18; any_change=1 in the same cycle; other channels stay 0.
2. Bounce sw_in[1]: 1 for 10 cycles, 0 for 2, then 1 steady -> no premature change; sw_out[1] rises 18 edges after the final stable sample.
3. Release a debounced channel -> fall pulses once, 18 edges after the release is first sampled; rise stays 0.
4. tick pulsed every 4th cycle, sw_in[2] stable high -> sw_out[2] asserts after 16 ticks past the synchroniser (about 64 clocks). Drop tick for 20 cycles mid-window -> the counter freezes, then completes later.
5. Assert reset at cnt=10 with sw_in[3]=1 -> all outputs 0 immediately. After release, the full 18-edge window restarts and no spurious pulses occur.
6. With SYNC_DEBOUNCE_HOLD_EN and HOLD_DEPTH=5, hold sw_in[0] high -> exactly one hold[0] pulse 31 ticks after sw_out[0] rises. Without the macro, hold stays 0.
